// File: rtl/pipelined_extender.sv
// Registered immediate-extension unit (zero / sign / shifted-zero) with a main + skid output buffer.
// Optional accept counter on stat_count when PIPELINED_EXTENDER_STATS_EN is defined.
module pipelined_extender #(
  parameter int IN_LENGTH  = 9,
  parameter int OUT_LENGTH = 64,
  parameter int SHIFT_STEP = 16,
  parameter int HW_BITS    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [IN_LENGTH-1:0]  in_data,
  input  logic [1:0]            in_mode,
  input  logic [HW_BITS-1:0]    in_hw,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_LENGTH-1:0] out_data,
  output logic                  out_err,
  output logic [31:0]           stat_count
);

  function automatic logic [OUT_LENGTH-1:0] zero_ext(input logic [IN_LENGTH-1:0] d);
    return {{(OUT_LENGTH-IN_LENGTH){1'b0}}, d};
  endfunction

  function automatic logic [OUT_LENGTH-1:0] sign_ext(input logic signed [IN_LENGTH-1:0] d);
    logic signed [OUT_LENGTH-1:0] r;
    r = OUT_LENGTH'(d);
    return r;
  endfunction

  // Placement past the top of the word yields zero rather than a wrapped shift.
  function automatic logic [OUT_LENGTH-1:0] shift_ext(input logic [IN_LENGTH-1:0] d,
                                                      input logic [HW_BITS-1:0] hw);
    int sh;
    sh = int'(hw) * SHIFT_STEP;
    if (sh >= OUT_LENGTH) return '0;
    return zero_ext(d) << sh;
  endfunction

  // Stage p0: combinational extension of the offered immediate
  logic [OUT_LENGTH-1:0] ext_p0;
  logic                  err_p0;

  always_comb begin
    ext_p0 = '0;
    err_p0 = 1'b0;
    case (in_mode)
      2'd0:    ext_p0 = zero_ext(in_data);
      2'd1:    ext_p0 = sign_ext(in_data);
      2'd2:    ext_p0 = shift_ext(in_data, in_hw);
      default: begin
        ext_p0 = zero_ext(in_data);
        err_p0 = 1'b1;
      end
    endcase
  end

  // Stage p1: main output register plus skid register
  logic                  vld_p1;
  logic [OUT_LENGTH-1:0] data_p1;
  logic                  err_p1;
  logic                  skid_vld_p1;
  logic [OUT_LENGTH-1:0] skid_data_p1;
  logic                  skid_err_p1;
  logic                  rdy_p1;

  logic accept, xfer, main_load, skid_load, skid_pop, skid_vld_next;

  assign accept        = in_valid & rdy_p1;
  assign xfer          = vld_p1 & out_ready;
  assign main_load     = accept & (~vld_p1 | xfer);
  assign skid_load     = accept & vld_p1 & ~xfer;
  assign skid_pop      = skid_vld_p1 & xfer;
  assign skid_vld_next = skid_load | (skid_vld_p1 & ~skid_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      err_p1      <= 1'b0;
      skid_vld_p1 <= 1'b0;
      rdy_p1      <= 1'b0;
    end else begin
      rdy_p1      <= ~skid_vld_next;
      skid_vld_p1 <= skid_vld_next;
      if (skid_pop) begin
        vld_p1  <= 1'b1;
        data_p1 <= skid_data_p1;
        err_p1  <= skid_err_p1;
      end else if (main_load) begin
        vld_p1  <= 1'b1;
        data_p1 <= ext_p0;
        err_p1  <= err_p0;
      end else if (xfer) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  // Skid payload is only meaningful while skid_vld_p1 is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_p1 <= ext_p0;
      skid_err_p1  <= err_p0;
    end
  end

  assign in_ready  = rdy_p1;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_err   = err_p1;

`ifdef PIPELINED_EXTENDER_STATS_EN
  logic [31:0] stat_p1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_p1 <= 32'h0;
    end else if (accept) begin
      stat_p1 <= stat_p1 + 32'd1;
    end
  end

  assign stat_count = stat_p1;
`else
  assign stat_count = 32'h0;
`endif

endmodule

// File: tb/tb_pipelined_extender.sv
// Bench for pipelined_extender: directed latency/backpressure/reset cases plus a randomized
// sweep scored against a queue-based reference model.
module tb_pipelined_extender;
  localparam int IN_LENGTH  = 9;
  localparam int OUT_LENGTH = 64;
  localparam int SHIFT_STEP = 16;
  localparam int HW_BITS    = 2;
`ifdef PIPELINED_EXTENDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic [IN_LENGTH-1:0]  in_data = '0;
  logic [1:0]            in_mode = '0;
  logic [HW_BITS-1:0]    in_hw = '0;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic [OUT_LENGTH-1:0] out_data;
  logic                  out_err;
  logic [31:0]           stat_count;

  pipelined_extender #(
    .IN_LENGTH(IN_LENGTH), .OUT_LENGTH(OUT_LENGTH),
    .SHIFT_STEP(SHIFT_STEP), .HW_BITS(HW_BITS)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mode(in_mode), .in_hw(in_hw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .stat_count(stat_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned acc_cnt  = 0;
  bit          mon_en   = 1'b0;
  logic [64:0] exp_q[$];

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: {err, data} computed from the arithmetic rules directly.
  function automatic logic [64:0] ref_ext(input int d, input int mode, input int hw);
    longint r;
    int     sh;
    r = longint'(d);
    if (mode == 1 && d >= 256) r = r - 512;
    if (mode == 2) begin
      sh = hw * SHIFT_STEP;
      r = (sh >= 64) ? 64'sd0 : (r << sh);
    end
    return {(mode == 3), 64'(r)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: decisions are visible mid-cycle and take effect at the next rising edge.
  always @(negedge clk) begin
    logic [64:0] e;
    if (reset) begin
      exp_q.delete();
      acc_cnt = 0;
    end else begin
      if (in_valid && in_ready) begin
        acc_cnt++;
        if (mon_en) exp_q.push_back(ref_ext(int'(in_data), int'(in_mode), int'(in_hw)));
      end
      if (mon_en && out_valid && out_ready) begin
        chk_val("sweep_expected_pending", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk_val("sweep_data", out_data, e[63:0]);
          chk_val("sweep_err", 64'(out_err), 64'(e[64]));
        end
      end
    end
  end

  task automatic send(input logic [8:0] d, input logic [1:0] m, input logic [1:0] h, input bit rnd);
    bit done;
    int cyc;
    done = 1'b0;
    cyc  = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_hw    = h;
    while (!done && cyc < 1000) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!done) chk_val("accept_timeout", 64'(done), 64'd1);
    in_valid = 1'b0;
  endtask

  logic [8:0]  d_tab[6]   = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h0AB, 9'h1AB, 9'h100};
  logic [1:0]  m_tab[6]   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};
  logic [1:0]  h_tab[6]   = '{2'd0, 2'd0, 2'd2, 2'd3, 2'd3, 2'd0};
  logic [63:0] x_tab[6]   = '{64'h0000_0000_0000_01FF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h0000_01FF_0000_0000, 64'h00AB_0000_0000_0000,
                              64'h01AB_0000_0000_0000, 64'h0000_0000_0000_0100};
  logic        e_tab[6]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int cyc;
    // Reset state
    repeat (2) @(posedge clk);
    #2;
    chk_val("rst_out_valid", 64'(out_valid), 64'd0);
    chk_val("rst_out_data", out_data, 64'd0);
    chk_val("rst_out_err", 64'(out_err), 64'd0);
    chk_val("rst_in_ready", 64'(in_ready), 64'd0);
    chk_val("rst_stat", 64'(stat_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_val("rdy_on_release", 64'(in_ready), 64'd0);
    step();
    chk_val("rdy_first_clock", 64'(in_ready), 64'd1);

    // Directed stream, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1;
      in_data  = d_tab[i];
      in_mode  = m_tab[i];
      in_hw    = h_tab[i];
      step();
      chk_val($sformatf("stream%0d_valid", i), 64'(out_valid), 64'd1);
      chk_val($sformatf("stream%0d_data", i), out_data, x_tab[i]);
      chk_val($sformatf("stream%0d_err", i), 64'(out_err), 64'(e_tab[i]));
    end
    in_valid = 1'b0;
    step();
    chk_val("stream_drained", 64'(out_valid), 64'd0);

    // Backpressure: A, B accepted, C held
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 2'd0; in_hw = '0;
    in_data = 9'd1;
    step();
    chk_val("bp_rdy_after_A", 64'(in_ready), 64'd1);
    in_data = 9'd2;
    step();
    chk_val("bp_rdy_after_B", 64'(in_ready), 64'd0);
    in_data = 9'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_val("bp_hold_data", out_data, 64'd1);
      chk_val("bp_hold_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    chk_val("bp_B_data", out_data, 64'd2);
    chk_val("bp_rdy_back", 64'(in_ready), 64'd1);
    step();
    chk_val("bp_C_data", out_data, 64'd3);
    in_valid = 1'b0;
    step();
    chk_val("bp_empty", 64'(out_valid), 64'd0);

    // Mid-flight asynchronous reset
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 9'd5;
    step();
    in_data = 9'd6;
    step();
    in_valid = 1'b0;
    #3;
    reset = 1'b1;
    #1;
    chk_val("midrst_valid_drop", 64'(out_valid), 64'd0);
    chk_val("midrst_rdy", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_val("midrst_no_stale", 64'(out_valid), 64'd0);
    end

    // Randomized sweep against the reference model
    mon_en = 1'b1;
    for (int m = 0; m < 2; m++)
      for (int d = 0; d < 512; d++)
        send(9'(d), 2'(m), 2'($urandom_range(0, 3)), 1'b1);
    for (int i = 0; i < 200; i++)
      send(9'($urandom_range(0, 511)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 50) begin
      step();
      cyc++;
    end
    step();
    chk_val("sweep_drain", 64'(exp_q.size()), 64'd0);
    mon_en = 1'b0;

    // Accept counter
    chk_val("stat_count", 64'(stat_count), STATS ? 64'(acc_cnt) : 64'd0);
    #2;
    reset = 1'b1;
    #1;
    chk_val("stat_reset", 64'(stat_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
